uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: NREQ, 4, number of requesters (fixed at 4; the round-robin and grant_id width are sized for 4).
REQ-002 Parameter: TIMEOUT, 16, max cycles from tx_start to tx_busy rise before error.
REQ-003 Port: clk  in  1  single system clock; all logic on rising edge.
REQ-004 Port: rst  in  1  reset, synchronous, active-high.
REQ-005 Port: req  in  4  per-requester transmit request; bit i = requester i.
REQ-006 Port: req_data  in  32  byte for requester i on bits [8i+7:8i].
REQ-007 Port: ack  out  4  one-cycle pulse; bit i = requester i's byte accepted.
REQ-008 Port: tx_start  out  1  one-cycle start pulse to the shared UART transmitter.
REQ-009 Port: tx_data  out  8  byte to the transmitter.
REQ-010 Port: tx_busy  in  1  transmitter busy; high for the whole frame.
REQ-011 Port: grant_id  out  2  index of the current or last granted requester.
REQ-012 Port: active  out  1  high whenever the FSM is not in IDLE.
REQ-013 Port: err_timeout  out  1  sticky flag; tx_busy failed to rise within TIMEOUT.

Function
REQ-014 FSM states: IDLE, WAIT_BUSY, WAIT_DONE.
REQ-015 IDLE: grant only when req != 0 and tx_busy == 0; otherwise stay in IDLE.
REQ-016 Arbitration: round-robin; search starts at (last_grant+1) mod 4 and picks the first set req bit.
REQ-017 Grant latency: req sampled at edge N -> at cycle N+1:
  - tx_start=1 and ack[winner]=1, both for exactly one cycle
  - tx_data = winner's byte
  - grant_id = winner
  - state = WAIT_BUSY
REQ-018 last_grant updates to the winner on the grant cycle.
REQ-019 tx_data holds stable from tx_start until the FSM re-enters IDLE.
REQ-020 Requester protocol: hold req and req_data until ack.
  - Dropping req before ack withdraws the request; no ack is issued.
  - req still high after ack is treated as a new request.
REQ-021 WAIT_BUSY: counter clears on the grant cycle and increments each cycle while tx_busy=0.
  - tx_busy=1 -> WAIT_DONE.
  - Counter reaches TIMEOUT with tx_busy still 0 -> err_timeout=1, return to IDLE; the byte is dropped.
REQ-022 WAIT_DONE: tx_busy=0 -> IDLE.
REQ-023 Re-grant: at least one IDLE cycle precedes each new grant; the earliest next tx_start is 2 cycles after tx_busy falls.
REQ-024 Counter width is clog2(TIMEOUT+1) bits and saturates; it never wraps.
REQ-025 err_timeout is sticky; only rst clears it.
REQ-026 active=0 in IDLE and 1 in WAIT_BUSY and WAIT_DONE.
REQ-027 ack and tx_start never assert outside the grant cycle.
REQ-028 At most one ack bit is high in any cycle.

Reset
REQ-029 rst=1 forces, on the next edge:
  - state=IDLE, last_grant=3 (requester 0 first after reset)
  - ack=0, tx_start=0, tx_data=0x00, grant_id=0, active=0, err_timeout=0, counter=0
REQ-030 Reset mid-frame drops any in-flight arbitration state and issues no ack; this block does not abort a transmitter frame already started.
REQ-031 After rst deasserts, the first grant occurs no earlier than one cycle later.

Verification
REQ-032 Single request:
  - Stimulus: req=0001, data0=0x55; model tx_busy high 3 cycles after start, for 20 cycles.
  - Response: ack=0001 and tx_start with tx_data=0x55 one cycle later; active high until tx_busy falls.
REQ-033 All four request continuously:
  - Response: grant order 0,1,2,3,0.
  - Exactly one ack per frame; tx_data matches each requester's byte.
REQ-034 Timeout with TIMEOUT=16:
  - Stimulus: tx_busy held 0 after grant.
  - Response: err_timeout=1 after 16 cycles; FSM back to IDLE; next request still granted; err_timeout stays 1.
REQ-035 External busy:
  - Stimulus: tx_busy=1 while idle with req=0010.
  - Response: no grant; grant occurs the cycle after tx_busy falls.
REQ-036 Withdraw:
  - Stimulus: req=0100 dropped in the same cycle tx_busy releases.
  - Response: no ack and no tx_start for requester 2.
REQ-037 Reset mid-WAIT_DONE:
  - Response: all outputs zero the next cycle.
  - Next grant with req=1111 goes to requester 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets four requesters share one UART transmitter.
// Each grant hands one byte to the transmitter, then waits for the frame to finish before the next grant.
module uart_tx_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   ack,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic [1:0]        grant_id,
  output logic              active,
  output logic              err_timeout
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [1:0]      last_grant, last_grant_n;
  logic [CW-1:0]   cnt, cnt_n, cnt_inc;
  logic [NREQ-1:0] ack_n;
  logic            tx_start_n;
  logic [7:0]      tx_data_n;
  logic [1:0]      grant_id_n;
  logic            active_n;
  logic            err_n;
  logic [1:0]      win;
  logic [1:0]      idx;
  logic            found;

  // Round-robin pick: first set request at or after last_grant+1, wrapping.
  always_comb begin
    win   = last_grant;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = last_grant + 2'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  assign cnt_inc = (cnt == CW'(TIMEOUT)) ? cnt : cnt + CW'(1);

  // Next-state and next-output logic.
  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    cnt_n        = cnt;
    ack_n        = '0;
    tx_start_n   = 1'b0;
    tx_data_n    = tx_data;
    grant_id_n   = grant_id;
    err_n        = err_timeout;

    case (state)
      IDLE: begin
        if (found && !tx_busy) begin
          state_n      = WAIT_BUSY;
          ack_n[win]   = 1'b1;
          tx_start_n   = 1'b1;
          tx_data_n    = req_data[{win, 3'b000} +: 8];
          grant_id_n   = win;
          last_grant_n = win;
          cnt_n        = '0;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_n = WAIT_DONE;
        end else begin
          cnt_n = cnt_inc;
          // Transmitter never picked up the byte: flag it and drop the byte.
          if (cnt_inc == CW'(TIMEOUT)) begin
            err_n   = 1'b1;
            state_n = IDLE;
          end
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    active_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= 2'd3;
      cnt         <= '0;
      ack         <= '0;
      tx_start    <= 1'b0;
      tx_data     <= 8'h00;
      grant_id    <= 2'd0;
      active      <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      last_grant  <= last_grant_n;
      cnt         <= cnt_n;
      ack         <= ack_n;
      tx_start    <= tx_start_n;
      tx_data     <= tx_data_n;
      grant_id    <= grant_id_n;
      active      <= active_n;
      err_timeout <= err_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table plus hand sequences,
// with every grant checked by a scoreboard fed from the stimulus side.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  ack;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        active;
  logic        err_timeout;

  logic        model_busy = 1'b0;
  logic        ext_busy   = 1'b0;
  logic        model_en   = 1'b1;
  int          busy_delay = 3;
  int          busy_len   = 20;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic [3:0] req;
    logic [1:0] win;
    logic [7:0] data;
  } vec_t;
  vec_t tbl[8];

  localparam logic [31:0] TD = 32'hC3962B55;

  assign tx_busy = model_busy | ext_busy;

  uart_tx_arbiter #(.NREQ(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .grant_id(grant_id), .active(active), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [1:0] id, input logic [7:0] d);
    exp_t e;
    e.id = id;
    e.data = d;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick();
    rst = 1'b0;
    check("rst_ack", 32'(ack), 0);
    check("rst_tx_start", 32'(tx_start), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_grant_id", 32'(grant_id), 0);
    check("rst_active", 32'(active), 0);
    check("rst_err", 32'(err_timeout), 0);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!(active === 1'b0 && tx_busy === 1'b0) && n < 200) begin
      tick();
      if (tx_busy === 1'b1 && model_busy === 1'b1) check({name, "_active_busy"}, 32'(active), 1);
      n++;
    end
    check({name, "_idle_timeout"}, 32'(n < 200), 1);
  endtask

  task automatic wait_start(input string name);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (tx_start !== 1'b1 && n < 200);
    check({name, "_start_timeout"}, 32'(tx_start === 1'b1), 1);
  endtask

  // Transmitter model: busy rises busy_delay cycles after tx_start, lasts busy_len cycles.
  initial begin
    forever begin
      tick();
      if (model_en && tx_start === 1'b1) begin
        repeat (busy_delay) @(posedge clk);
        #1 model_busy = 1'b1;
        repeat (busy_len) @(posedge clk);
        #1 model_busy = 1'b0;
      end
    end
  end

  // Scoreboard monitor: every grant must match the next expected grant.
  initial begin
    exp_t e;
    forever begin
      tick();
      if (tx_start === 1'b1 || |ack === 1'b1) begin
        check("ack_onehot", 32'($countones(ack)), 1);
        check("start_with_ack", 32'(tx_start), 1);
        if (sb_q.size() == 0) begin
          check("sb_underflow", 32'(sb_q.size()), 1);
        end else begin
          e = sb_q.pop_front();
          check("sb_grant_id", 32'(grant_id), 32'(e.id));
          check("sb_tx_data", 32'(tx_data), 32'(e.data));
          check("sb_ack", 32'(ack), 32'(4'b0001 << e.id));
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    tbl[0] = '{4'b0001, 2'd0, 8'h55};
    tbl[1] = '{4'b1010, 2'd1, 8'h2B};
    tbl[2] = '{4'b1010, 2'd3, 8'hC3};
    tbl[3] = '{4'b1010, 2'd1, 8'h2B};
    tbl[4] = '{4'b0100, 2'd2, 8'h96};
    tbl[5] = '{4'b1001, 2'd3, 8'hC3};
    tbl[6] = '{4'b1111, 2'd0, 8'h55};
    tbl[7] = '{4'b0110, 2'd1, 8'h2B};

    do_reset();

    // Single transactions, round-robin order from a known reset state.
    for (int i = 0; i < 8; i++) begin
      wait_idle($sformatf("tbl%0d_pre", i));
      req_data = TD;
      req = tbl[i].req;
      push(tbl[i].win, tbl[i].data);
      tick();
      check($sformatf("tbl%0d_latency", i), 32'(tx_start), 1);
      check($sformatf("tbl%0d_active", i), 32'(active), 1);
      req = '0;
      wait_idle($sformatf("tbl%0d_post", i));
    end

    // All four requesting continuously.
    do_reset();
    w = 32'h44332211;
    req_data = w;
    push(2'd0, w[7:0]);
    push(2'd1, w[15:8]);
    push(2'd2, w[23:16]);
    push(2'd3, w[31:24]);
    push(2'd0, w[7:0]);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) wait_start($sformatf("rr%0d", k));
    req = '0;
    wait_idle("rr_end");

    // Transmitter never goes busy: timeout after 16 cycles.
    do_reset();
    req_data = TD;
    model_en = 1'b0;
    req = 4'b0100;
    push(2'd2, 8'h96);
    tick();
    check("to_latency", 32'(tx_start), 1);
    req = '0;
    repeat (15) tick();
    check("to_err_early", 32'(err_timeout), 0);
    check("to_active_early", 32'(active), 1);
    tick();
    check("to_err_set", 32'(err_timeout), 1);
    check("to_back_idle", 32'(active), 0);
    model_en = 1'b1;
    req = 4'b1000;
    push(2'd3, 8'hC3);
    tick();
    check("to_regrant", 32'(tx_start), 1);
    req = '0;
    wait_idle("to_regrant");
    check("to_err_sticky", 32'(err_timeout), 1);

    // External busy blocks grant until it falls.
    do_reset();
    req_data = TD;
    ext_busy = 1'b1;
    req = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("ext_hold", 32'(tx_start), 0);
    end
    ext_busy = 1'b0;
    push(2'd1, 8'h2B);
    tick();
    check("ext_release", 32'(tx_start), 1);
    req = '0;
    wait_idle("ext");

    // Request withdrawn the same cycle busy releases.
    ext_busy = 1'b1;
    req = 4'b0100;
    repeat (3) tick();
    ext_busy = 1'b0;
    req = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("wd_no_start", 32'(tx_start), 0);
      check("wd_no_ack", 32'(ack), 0);
    end

    // Reset while waiting for the frame to finish.
    do_reset();
    req_data = TD;
    req = 4'b0010;
    push(2'd1, 8'h2B);
    tick();
    check("rmid_grant", 32'(tx_start), 1);
    req = '0;
    for (int n = 0; n < 50 && tx_busy !== 1'b1; n++) tick();
    repeat (2) tick();
    check("rmid_active", 32'(active), 1);
    do_reset();
    req = 4'b1111;
    push(2'd0, 8'h55);
    for (int n = 0; n < 100 && ack[0] !== 1'b1; n++) tick();
    check("rmid_first_ack", 32'(ack), 32'h1);
    req = '0;
    wait_idle("rmid_end");

    repeat (3) tick();
    check("sb_drain", 32'(sb_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
